// File: rtl/brightness_fade_ctrl_pkg.sv
// Shared constants, state type and channel packing for the brightness fade
// sequencer and Brightness_PWM.
package brightness_pkg;

   localparam int NUM_CH = 6;
   localparam int CH_W   = 8;
   localparam int RATE_W = 8;

   localparam logic [CH_W-1:0] PERIOD_LAST = {CH_W{1'b1}};
   localparam logic [CH_W-1:0] STEP_POINT  = {{(CH_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      IDLE,
      FADE,
      DONE
   } fade_state_t;

   // Channel 0 sits in the least significant CH_W bits, matching DATA_i.
   function automatic logic [CH_W-1:0] ch_slice(input logic [NUM_CH*CH_W-1:0] word,
                                                input int unsigned idx);
      return word[idx*CH_W +: CH_W];
   endfunction

endpackage

// File: rtl/brightness_fade_ctrl_ch_step.sv
// One brightness channel: moves its registered level one LSB toward the
// target whenever a step is enabled, never overshooting.
module fade_ch_step
   import brightness_pkg::*;
(
   input  logic            sys_clk,
   input  logic            sys_resetb,
   input  logic [CH_W-1:0] cur,
   input  logic [CH_W-1:0] tgt,
   input  logic            step_en,
   output logic [CH_W-1:0] nxt,
   output logic            eq
);

   logic [CH_W-1:0] stepped;

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      stepped = cur;
      if (cur < tgt) begin
         stepped = cur + CH_W'(1);
      end else if (cur > tgt) begin
         stepped = cur - CH_W'(1);
      end
   end

   assign eq = (cur == tgt);

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update from the same pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (!sys_resetb) begin
         nxt <= '0;
      end else if (step_en) begin
         nxt <= stepped;
      end
   end

endmodule

// File: rtl/brightness_fade_ctrl.sv
// Fade sequencer in front of Brightness_PWM: ramps the duty word toward a
// target one LSB per step, updating only on PWM period boundaries.
module brightness_fade_ctrl
   import brightness_pkg::*;
(
   input  logic                   sys_clk,
   input  logic                   sys_resetb,
   input  logic [NUM_CH*CH_W-1:0] tgt_i,
   input  logic                   tgt_valid_i,
   output logic                   tgt_ready_o,
   input  logic [RATE_W-1:0]      rate_i,
   output logic [NUM_CH*CH_W-1:0] DATA_o,
   output logic                   CTS_o,
   output logic                   busy_o,
   output logic                   done_o
);

   fade_state_t                   state, state_nxt;
   logic [CH_W-1:0]               period_cnt;
   logic [RATE_W-1:0]             tick_cnt, tick_inc, rate_q;
   logic [NUM_CH*CH_W-1:0]        tgt_q;
   logic [NUM_CH-1:0][CH_W-1:0]   ch_cur;
   logic [NUM_CH-1:0][CH_W-1:0]   ch_tgt;
   logic [NUM_CH-1:0]             ch_eq;
   logic                          step_pt, step_en, accept;

   assign step_pt  = (period_cnt == STEP_POINT);
   assign tick_inc = tick_cnt + RATE_W'(1);
   assign accept   = tgt_valid_i && tgt_ready_o;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_tgt[i] = ch_slice(tgt_q, i);

      fade_ch_step u_step (
         .sys_clk    (sys_clk),
         .sys_resetb (sys_resetb),
         .cur        (ch_cur[i]),
         .tgt        (ch_tgt[i]),
         .step_en    (step_en),
         .nxt        (ch_cur[i]),
         .eq         (ch_eq[i])
      );
   end

   assign DATA_o = ch_cur;

   always_comb begin
      state_nxt   = state;
      step_en     = 1'b0;
      tgt_ready_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state)
         IDLE: begin
            tgt_ready_o = 1'b1;
            if (tgt_valid_i) state_nxt = FADE;
         end
         FADE: begin
            busy_o  = 1'b1;
            step_en = step_pt && (tick_inc == rate_q);
            // CTS_o is only ever high in the FF cycle, so leaving here lands DONE on 00.
            if (CTS_o && (&ch_eq)) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_resetb) begin
         state      <= IDLE;
         period_cnt <= '0;
         tick_cnt   <= '0;
         CTS_o      <= 1'b0;
      end else begin
         state      <= state_nxt;
         period_cnt <= period_cnt + CH_W'(1);
         CTS_o      <= step_en;
         if (accept) begin
            tick_cnt <= '0;
         end else if ((state == FADE) && step_pt) begin
            tick_cnt <= step_en ? '0 : tick_inc;
         end
      end
   end

   // NOTE: the target and rate holding registers carry no reset; they are
   // always loaded at accept before FADE ever reads them.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         tgt_q  <= tgt_i;
         rate_q <= (rate_i == '0) ? RATE_W'(1) : rate_i;
      end
   end

endmodule

// File: tb/tb_brightness_fade_ctrl.sv
// Directed bench for brightness_fade_ctrl: expected CTS data words are queued
// when a target is offered and popped when the DUT strobes CTS.
module tb_brightness_fade_ctrl;
   import brightness_pkg::*;

   localparam int W = NUM_CH*CH_W;

   logic          sys_clk = 1'b0;
   logic          sys_resetb;
   logic [W-1:0]  tgt_i;
   logic          tgt_valid_i;
   logic          tgt_ready_o;
   logic [7:0]    rate_i;
   logic [W-1:0]  DATA_o;
   logic          CTS_o;
   logic          busy_o;
   logic          done_o;

   int            assert_cnt = 0;
   int            fail_cnt   = 0;
   int            cts_seen   = 0;
   int            cts_planned = 0;
   int            cyc = 0;
   logic [7:0]    mdl_cnt = '0;
   logic [W-1:0]  mdl_data = '0;
   logic [W-1:0]  exp_q[$];
   int            cts_cyc[$];

   brightness_fade_ctrl dut (
      .sys_clk     (sys_clk),
      .sys_resetb  (sys_resetb),
      .tgt_i       (tgt_i),
      .tgt_valid_i (tgt_valid_i),
      .tgt_ready_o (tgt_ready_o),
      .rate_i      (rate_i),
      .DATA_o      (DATA_o),
      .CTS_o       (CTS_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      if (!sys_resetb) mdl_cnt <= '0;
      else             mdl_cnt <= mdl_cnt + 8'd1;
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] set_ch(input logic [W-1:0] w, input int ch, input logic [7:0] v);
      logic [W-1:0] r;
      r = w;
      r[ch*CH_W +: CH_W] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] model_step(input logic [W-1:0] cur, input logic [W-1:0] tgt);
      logic [W-1:0] r;
      logic [7:0]   c, t;
      r = cur;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         c = ch_slice(cur, ch);
         t = ch_slice(tgt, ch);
         if (c < t)      r = set_ch(r, ch, c + 8'd1);
         else if (c > t) r = set_ch(r, ch, c - 8'd1);
      end
      return r;
   endfunction

   task automatic plan_fade(input logic [W-1:0] tgt);
      do begin
         mdl_data = model_step(mdl_data, tgt);
         exp_q.push_back(mdl_data);
         cts_planned++;
      end while (mdl_data != tgt);
   endtask

   always @(negedge sys_clk) begin
      if (sys_resetb === 1'b1 && CTS_o === 1'b1) begin
         cts_seen++;
         cts_cyc.push_back(cyc);
         check("cts_phase", W'(mdl_cnt), W'(PERIOD_LAST));
         if (exp_q.size() != 0) check("cts_data", DATA_o, exp_q.pop_front());
      end
   end

   task automatic wait_cnt(input logic [7:0] v);
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if (mdl_cnt == v) return;
      end
      check("wait_cnt", W'(mdl_cnt), W'(v));
   endtask

   task automatic offer(input logic [W-1:0] tgt, input logic [7:0] rate, input logic [7:0] at_cnt);
      wait_cnt(at_cnt);
      check("ready_idle", W'(tgt_ready_o), W'(1));
      tgt_i       = tgt;
      rate_i      = rate;
      tgt_valid_i = 1'b1;
      plan_fade(tgt);
      @(negedge sys_clk);
      tgt_valid_i = 1'b0;
      check("busy_after_accept", W'(busy_o), W'(1));
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < 4000) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_done"}, W'(done_o), W'(1));
      check({tag, "_done_phase"}, W'(mdl_cnt), W'(0));
      check({tag, "_busy_in_done"}, W'(busy_o), W'(0));
      check({tag, "_ready_in_done"}, W'(tgt_ready_o), W'(0));
      check({tag, "_data"}, DATA_o, mdl_data);
      check({tag, "_cts_count"}, W'(cts_seen), W'(cts_planned));
      @(negedge sys_clk);
      check({tag, "_done_single"}, W'(done_o), W'(0));
      check({tag, "_ready_after"}, W'(tgt_ready_o), W'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] t;

      sys_resetb  = 1'b0;
      tgt_i       = '0;
      tgt_valid_i = 1'b0;
      rate_i      = 8'd1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_data", DATA_o, '0);
      check("rst_cts", W'(CTS_o), W'(0));
      check("rst_busy", W'(busy_o), W'(0));
      check("rst_done", W'(done_o), W'(0));
      check("rst_ready", W'(tgt_ready_o), W'(1));
      sys_resetb = 1'b1;

      // Up fade: ch0 0 -> 3 at rate 1.
      offer(set_ch('0, 0, 8'h03), 8'd1, 8'h10);
      wait_done("up");

      // A low pulse between edges must not reset anything.
      @(negedge sys_clk);
      #2 sys_resetb = 1'b0;
      #2 sys_resetb = 1'b1;
      @(negedge sys_clk);
      check("glitch_data", DATA_o, mdl_data);
      check("glitch_ready", W'(tgt_ready_o), W'(1));

      // Set up ch5=5, ch0 back to 0.
      offer(set_ch('0, 5, 8'h05), 8'd1, 8'h40);
      wait_done("setup");

      // Mixed directions, rate 0 behaves as rate 1.
      cts_cyc.delete();
      t = set_ch(set_ch('0, 5, 8'h03), 1, 8'h02);
      offer(t, 8'd0, 8'h22);
      wait_done("mixed");
      check("mixed_pulses", W'(cts_cyc.size()), W'(2));
      if (cts_cyc.size() == 2) check("mixed_spacing", W'(cts_cyc[1] - cts_cyc[0]), W'(256));

      // Rate 4: two steps, 4 periods apart.
      cts_cyc.delete();
      t = set_ch(t, 0, 8'h02);
      offer(t, 8'd4, 8'h10);
      wait_done("rate4");
      check("rate4_pulses", W'(cts_cyc.size()), W'(2));
      if (cts_cyc.size() == 2) check("rate4_spacing", W'(cts_cyc[1] - cts_cyc[0]), W'(1024));

      // Back-pressure: a second target held valid during the fade.
      wait_cnt(8'h20);
      t = set_ch(t, 0, 8'h04);
      tgt_i = t;
      rate_i = 8'd1;
      tgt_valid_i = 1'b1;
      plan_fade(t);
      @(negedge sys_clk);
      tgt_i = set_ch(set_ch(t, 0, 8'h01), 2, 8'h02);
      check("bp_ready_low", W'(tgt_ready_o), W'(0));
      wait_cnt(8'h80);
      check("bp_ready_mid", W'(tgt_ready_o), W'(0));
      check("bp_busy_mid", W'(busy_o), W'(1));
      wait_done("bp_first");
      plan_fade(tgt_i);
      @(negedge sys_clk);
      tgt_valid_i = 1'b0;
      check("bp_second_busy", W'(busy_o), W'(1));
      wait_done("bp_second");

      // Target equal to the current level: one CTS, unchanged data.
      offer(mdl_data, 8'd2, 8'h30);
      wait_done("equal");

      // Reset in the middle of a fade.
      offer({NUM_CH{8'h40}}, 8'd1, 8'h10);
      wait_cnt(8'hFF);
      wait_cnt(8'h80);
      sys_resetb = 1'b0;
      @(negedge sys_clk);
      sys_resetb = 1'b1;
      cts_planned -= exp_q.size();
      exp_q.delete();
      mdl_data = '0;
      check("midrst_data", DATA_o, '0);
      check("midrst_busy", W'(busy_o), W'(0));
      check("midrst_cts", W'(CTS_o), W'(0));
      check("midrst_ready", W'(tgt_ready_o), W'(1));
      repeat (300) @(negedge sys_clk);
      check("midrst_no_cts", W'(cts_seen), W'(cts_planned));
      check("midrst_idle_data", DATA_o, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
